// File: rtl/audio_i2s_rx.sv
// I2S capture engine: synchronises BCLK/LRCK/DAT, deserialises per-slot samples into a FWFT FIFO.
// Define AUDIO_I2S_RX_LJ_EN for left-justified input (no one-bit delay after the LRCK edge).
module audio_i2s_rx #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int STEREO     = 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_en,
  input  logic                              i_AUD_BCLK,
  input  logic                              i_AUD_ADCLRCK,
  input  logic                              i_AUD_ADCDAT,
  output logic [SAMPLE_W-1:0]               o_data,
  output logic                              o_chan,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_level,
  output logic                              o_overflow,
  input  logic                              i_clr_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(SAMPLE_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_SKIP  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  // State entered on every LRCK edge: left-justified data starts immediately.
`ifdef AUDIO_I2S_RX_LJ_EN
  localparam logic [2:0] S_START = S_SHIFT;
`else
  localparam logic [2:0] S_START = S_SKIP;
`endif

  logic [2:0] bclk_q, lrck_q;
  logic [1:0] dat_q;
  logic       bclk_rise, lrck_edge, lrck, dat;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bclk_q <= '0;
      lrck_q <= '0;
      dat_q  <= '0;
    end else begin
      bclk_q <= {bclk_q[1:0], i_AUD_BCLK};
      lrck_q <= {lrck_q[1:0], i_AUD_ADCLRCK};
      dat_q  <= {dat_q[0], i_AUD_ADCDAT};
    end
  end

  assign bclk_rise = bclk_q[1] & ~bclk_q[2];
  assign lrck_edge = lrck_q[1] ^ lrck_q[2];
  assign lrck      = lrck_q[1];
  assign dat       = dat_q[1];

  logic [2:0]          state_q, state_d;
  logic                chan_q, chan_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d, word;
  logic                push;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    push    = 1'b0;
    word    = {shreg_q[SAMPLE_W-2:0], dat};
    if (!i_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ALIGN;
        S_ALIGN, S_HOLD: begin
          if (lrck_edge) begin
            state_d = S_START;
            chan_d  = lrck;
            cnt_d   = '0;
          end
        end
        S_SKIP: begin
          if (lrck_edge) begin
            chan_d = lrck;
          end else if (bclk_rise) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
          end
        end
        S_SHIFT: begin
          // A short slot abandons the partial word and restarts on the new channel.
          if (lrck_edge) begin
            state_d = S_START;
            chan_d  = lrck;
            cnt_d   = '0;
          end else if (bclk_rise) begin
            shreg_d = word;
            if (cnt_q == CW'(SAMPLE_W - 1)) begin
              state_d = S_HOLD;
              push    = (STEREO != 0) || !chan_q;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      chan_q  <= 1'b0;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  logic [SAMPLE_W:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, pop, full, wr_en, ovf_set;

  assign pop     = (level_q != '0) & i_ready;
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop)   rd_q <= rd_q + AW'(1);
      level_q <= level_d;
      ovf_q   <= (ovf_q & ~i_clr_ovf) | ovf_set;
    end
  end

  // NOTE: the storage array is deliberately not reset; outputs are masked while empty instead.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_q] <= {chan_q, word};
  end

  assign o_valid    = (level_q != '0);
  assign o_data     = o_valid ? mem[rd_q][SAMPLE_W-1:0] : '0;
  assign o_chan     = o_valid ? mem[rd_q][SAMPLE_W] : 1'b0;
  assign o_level    = level_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_audio_i2s_rx.sv
// Directed bench for audio_i2s_rx: stereo and mono instances share one codec stream model.
module tb_audio_i2s_rx;

`ifdef AUDIO_I2S_RX_LJ_EN
  localparam bit LJ = 1'b1;
`else
  localparam bit LJ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en, bclk, lrck, dat, ready, clr;

  logic [15:0] st_data, mo_data;
  logic        st_chan, st_valid, st_ovf, mo_chan, mo_valid, mo_ovf;
  logic [3:0]  st_level, mo_level;

  int n_vec = 0;
  int n_err = 0;

  logic [16:0] q_st[$];
  logic [16:0] q_mo[$];

  always #10 clk = ~clk;

  audio_i2s_rx #(.SAMPLE_W(16), .FIFO_DEPTH(8), .STEREO(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(lrck), .i_AUD_ADCDAT(dat),
    .o_data(st_data), .o_chan(st_chan), .o_valid(st_valid), .i_ready(ready),
    .o_level(st_level), .o_overflow(st_ovf), .i_clr_ovf(clr)
  );

  audio_i2s_rx #(.SAMPLE_W(16), .FIFO_DEPTH(8), .STEREO(0)) dut_m (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(lrck), .i_AUD_ADCDAT(dat),
    .o_data(mo_data), .o_chan(mo_chan), .o_valid(mo_valid), .i_ready(ready),
    .o_level(mo_level), .o_overflow(mo_ovf), .i_clr_ovf(clr)
  );

  // Record every handshake, sampled between clock edges once inputs have settled.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (st_valid && ready) q_st.push_back({st_chan, st_data});
      if (mo_valid && ready) q_mo.push_back({mo_chan, mo_data});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] get_st(input int i);
    return (i < q_st.size()) ? q_st[i] : 17'h1FFFF;
  endfunction

  function automatic logic [16:0] get_mo(input int i);
    return (i < q_mo.size()) ? q_mo[i] : 17'h1FFFF;
  endfunction

  // One BCLK period: LRCK and DAT change with the falling edge, 2 clk low, 2 clk high.
  task automatic send_period(input logic lr, input logic d);
    bclk = 1'b0;
    lrck = lr;
    dat  = d;
    repeat (2) @(negedge clk);
    bclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_slot(input logic lr, input logic [15:0] w, input bit lj, input int nper);
    for (int p = 0; p < nper; p++) begin
      logic b;
      b = 1'b0;
      if (lj) begin
        if (p < 16) b = w[15-p];
      end else if (p >= 1 && p <= 16) begin
        b = w[16-p];
      end
      send_period(lr, b);
    end
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; bclk = 1'b0; lrck = 1'b1; dat = 1'b0;
    ready = 1'b1; clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data",  32'(st_data),  32'h0);
    check("rst_chan",  32'(st_chan),  32'h0);
    check("rst_valid", 32'(st_valid), 32'h0);
    check("rst_level", 32'(st_level), 32'h0);
    check("rst_ovf",   32'(st_ovf),   32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (4) send_period(1'b1, 1'b0);

    // Stereo frame.
    send_slot(1'b0, 16'hA5A5, LJ, 20);
    send_slot(1'b1, 16'h5A5A, LJ, 20);
    settle();
    check("st_cnt",   32'(q_st.size()), 32'd2);
    check("st_left",  32'(get_st(0)), 32'h0A5A5);
    check("st_right", 32'(get_st(1)), 32'h15A5A);
    check("mo_cnt0",  32'(q_mo.size()), 32'd1);
    check("mo_left0", 32'(get_mo(0)), 32'h0A5A5);
    q_st.delete(); q_mo.delete();

    // Mono: only left slots reach the FIFO.
    for (int i = 1; i <= 4; i++) begin
      send_slot(1'b0, 16'(i), LJ, 20);
      send_slot(1'b1, 16'hFFFF, LJ, 20);
    end
    settle();
    check("mono_cnt", 32'(q_mo.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("mono_%0d", i), 32'(get_mo(i)), 32'(i + 1));
    q_st.delete(); q_mo.delete();

    // Overflow with the consumer stalled.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_slot(1'b0, 16'h1000 + 16'(i), LJ, 20);
      send_slot(1'b1, 16'h2000 + 16'(i), LJ, 20);
    end
    settle();
    check("ovf_level",    32'(st_level), 32'd8);
    check("ovf_flag",     32'(st_ovf),   32'h1);
    check("ovf_mo_level", 32'(mo_level), 32'd5);
    check("ovf_mo_flag",  32'(mo_ovf),   32'h0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("ovf_clr", 32'(st_ovf), 32'h0);
    ready = 1'b1;
    repeat (20) @(negedge clk);
    check("ovf_pop_cnt", 32'(q_st.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      logic [16:0] exp;
      exp = (k % 2 == 0) ? {1'b0, 16'h1000 + 16'(k / 2)} : {1'b1, 16'h2000 + 16'(k / 2)};
      check($sformatf("ovf_pop_%0d", k), 32'(get_st(k)), 32'(exp));
    end
    check("ovf_drained", 32'(st_level), 32'd0);
    check("ovf_mo_pop",  32'(q_mo.size()), 32'd5);
    q_st.delete(); q_mo.delete();

    // Enable dropped mid-slot.
    send_slot(1'b0, 16'h1234, LJ, 8);
    en = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);
    send_slot(1'b1, 16'h5678, LJ, 20);
    send_slot(1'b0, 16'h9ABC, LJ, 20);
    settle();
    check("en_cnt",   32'(q_st.size()), 32'd2);
    check("en_first", 32'(get_st(0)), 32'h15678);
    check("en_next",  32'(get_st(1)), 32'h09ABC);
    check("en_mono",  32'(get_mo(0)), 32'h09ABC);
    q_st.delete(); q_mo.delete();

    // Short left slot followed by a full right slot.
    send_slot(1'b1, 16'h7777, LJ, 20);
    send_slot(1'b0, 16'h1111, LJ, 11);
    send_slot(1'b1, 16'hBEEF, LJ, 20);
    settle();
    check("short_cnt",  32'(q_st.size()), 32'd2);
    check("short_pre",  32'(get_st(0)), 32'h17777);
    check("short_beef", 32'(get_st(1)), 32'h1BEEF);
    check("short_mono", 32'(q_mo.size()), 32'd0);
    q_st.delete(); q_mo.delete();

    // Left-justified stream: I2S framing sees it one bit late.
    send_slot(1'b0, 16'h8001, 1'b1, 20);
    send_slot(1'b1, 16'h0000, 1'b1, 20);
    settle();
    check("lj_left",  32'(get_st(0)), LJ ? 32'h08001 : 32'h00002);
    check("lj_right", 32'(get_st(1)), 32'h10000);
    check("lj_mono",  32'(get_mo(0)), LJ ? 32'h08001 : 32'h00002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/audio_i2s_rx.md
# audio_i2s_rx

Parametrised I2S capture engine for the audio recorder datapath: samples the codec's BCLK, ADCLRCK and ADCDAT in the system clock domain, deserialises left/right samples of configurable width, and queues them in an internal FIFO with a valid/ready handshake toward the SRAM writer. It replaces the fixed 16-bit, left-only recorder front end. Mono or stereo capture, FIFO depth and sample width are set at build time.

## Interface
- SAMPLE_W, 16: bits captured per channel slot (8..32).
- FIFO_DEPTH, 8: sample FIFO entries; power of two, ≥2.
- STEREO, 1: 1 = capture left and right; 0 = capture left only.
- i_clk  in  1  system clock (50 MHz); the only clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_en  in  1  capture enable (level).
- i_AUD_BCLK  in  1  codec bit clock, sampled as data.
- i_AUD_ADCLRCK  in  1  codec frame clock; 0 = left slot, 1 = right slot.
- i_AUD_ADCDAT  in  1  codec serial data, MSB first.
- o_data  out  SAMPLE_W  FIFO head sample.
- o_chan  out  1  channel of head sample (0 left, 1 right).
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  consumer accepts head when o_valid & i_ready.
- o_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- o_overflow  out  1  sticky: a completed sample was dropped because the FIFO was full.
- i_clr_ovf  in  1  synchronous clear of o_overflow.

## Operation
- BCLK, LRCK, DAT each pass a 2-flop synchroniser; a third BCLK/LRCK register gives rising-edge detect of BCLK and any-edge detect of LRCK.
- All serial activity is qualified on synchronised BCLK rising edges; LRCK and DAT are taken from the same synchronised sample.
- FSM states: IDLE, ALIGN, SKIP, SHIFT, HOLD.
  - IDLE: i_en=1 -> ALIGN.
  - ALIGN: wait for an LRCK edge (never start mid-slot) -> SKIP; latch channel = new LRCK level.
  - SKIP: on first BCLK rise -> SHIFT (I2S one-bit delay); bit counter = 0.
  - SHIFT: each BCLK rise shifts DAT into LSB, counter++; when counter reaches SAMPLE_W-1 and that bit is shifted, push {channel, word} -> HOLD.
  - HOLD: ignore extra BCLKs; next LRCK edge -> SKIP with new channel.
- STEREO=0: right-channel slots are traversed without pushing (no FIFO write, no overflow).
- LRCK edge while in SHIFT (short slot): partial word discarded, go to SKIP for the new slot.
- i_en deasserted in any state: next cycle -> IDLE, partial word discarded; FIFO contents and o_overflow retained; consumer may keep draining.
- FIFO: first-word-fall-through. Push when full and no pop that cycle: sample dropped, o_overflow set. Push and pop same cycle when full: both succeed, level unchanged. Pop when empty: ignored.
- i_clr_ovf and a new overflow in the same cycle: o_overflow stays 1.

## Timing
- Reset values: o_data 0, o_chan 0, o_valid 0, o_level 0, o_overflow 0, FSM IDLE, synchronisers 0.
- Input-to-edge-detect latency: 3 i_clk cycles after the pin transition.
- Push occurs on the cycle of the BCLK-rise detect carrying the last bit; o_valid, o_level update the following cycle.
- Pop: o_data/o_chan present the next entry the cycle after the handshake.
- Minimum BCLK high/low time: 2 i_clk periods (12 MHz BCLK at 50 MHz supported).
- Async reset asserted mid-slot: all state cleared immediately; after release, capture resynchronises via ALIGN.

## Configuration
- AUDIO_I2S_RX_LJ_EN defined: left-justified format; SKIP state bypassed, MSB captured on the first BCLK rise after the LRCK edge.
- Undefined: standard I2S, one BCLK delay after each LRCK edge.

## Test plan
- Stereo, SAMPLE_W=16, codec model sends L=16'hA5A5, R=16'h5A5A on 12 MHz BCLK, i_ready=1 -> two handshakes: {0,A5A5} then {1,5A5A}.
- STEREO=0, 4 frames L=16'h0001..16'h0004 -> exactly 4 pops, o_chan=0, values 1..4 in order.
- i_ready=0, FIFO_DEPTH=8, 5 stereo frames -> o_level=8, o_overflow=1, popped data = first 8 samples; i_clr_ovf -> o_overflow=0.
- i_en dropped after 7 bits of a left slot, re-raised -> that word never pushed; next complete slot captured correctly.
- LRCK toggled after 10 bits (short slot) -> partial discarded, following 16-bit right slot 16'hBEEF pushed with o_chan=1.
- Build with AUDIO_I2S_RX_LJ_EN, left-justified stream L=16'h8001 -> popped {0,8001}; same stream without macro yields a different word (shifted by one bit).
